// File: rtl/adf4351_cfg_seq_pkg.sv
// Shared definitions for the ADF4351 configuration sequencer: FSM encoding, register count
// and default timing parameters.
package adf4351_cfg_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrWait,
        StGap,
        StRdReq,
        StRdWait,
        StDone
    } state_e;

    localparam int unsigned NUM_REGS     = 6;
    localparam logic [19:0] POLL_DIV_DEF = 20'd400000;
    localparam logic [7:0]  GAP_CYC_DEF  = 8'd4;
    localparam logic [7:0]  TIMEOUT_DEF  = 8'd120;

    // Word idx of the packed register image; R0 sits in the low 32 bits.
    function automatic logic [31:0] reg_word(input logic [NUM_REGS*32-1:0] regs,
                                             input logic [2:0]             idx);
        return regs[{idx, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/adf4351_cfg_seq_poll.sv
// Power-detect poll tick generator: counts sys_clk cycles while enabled and pulses tick_o
// once every POLL_DIV cycles; disabling clears the count.
module cfg_poll_timer
    import adf4351_cfg_seq_pkg::*;
#(
    parameter logic [19:0] POLL_DIV = POLL_DIV_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    logic [19:0] cnt_q, cnt_d;
    logic        wrap;

    assign wrap   = (cnt_q == POLL_DIV - 20'd1);
    assign tick_o = en_i & wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 20'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adf4351_cfg_seq.sv
// ADF4351 configuration sequencer: on cfg_start writes R5..R0 through the SPI writer, and
// issues periodic power-detect reads through the SPI reader when polling is enabled.
module adf4351_cfg_seq
    import adf4351_cfg_seq_pkg::*;
#(
    parameter logic [19:0] POLL_DIV = POLL_DIV_DEF,
    parameter logic [7:0]  GAP_CYC  = GAP_CYC_DEF,
    parameter logic [7:0]  TIMEOUT  = TIMEOUT_DEF
) (
    input  logic         sys_clk,
    input  logic         rst_n,
    input  logic         cfg_start,
    input  logic [191:0] cfg_data,
    input  logic         poll_en,
    output logic [31:0]  wr_spi_data,
    output logic         wr_en,
    output logic         rd_en,
    input  logic         update_vld,
    input  logic [15:0]  spi_dout,
    input  logic         dout_vld,
    output logic         cfg_busy,
    output logic         cfg_done,
    output logic         cfg_err,
    output logic [15:0]  pwr_data,
    output logic         pwr_vld
);

    state_e                 state_q, state_d;
    logic [2:0]             reg_idx_q, reg_idx_d;
    logic [NUM_REGS*32-1:0] regs_q, regs_d;
    logic [7:0]             gap_cnt_q, gap_cnt_d;
    logic [7:0]             wait_cnt_q, wait_cnt_d;
    logic                   poll_pend_q, poll_pend_d;
    logic                   dout_vld_q;
    logic [31:0]            wr_spi_data_q, wr_spi_data_d;
    logic                   wr_en_q, wr_en_d;
    logic                   rd_en_q, rd_en_d;
    logic                   cfg_busy_q, cfg_busy_d;
    logic                   cfg_done_q, cfg_done_d;
    logic                   cfg_err_q, cfg_err_d;
    logic [15:0]            pwr_data_q, pwr_data_d;
    logic                   pwr_vld_q, pwr_vld_d;
    logic                   poll_tick;

    cfg_poll_timer #(
        .POLL_DIV (POLL_DIV)
    ) u_poll_timer (
        .clk_i  (sys_clk),
        .rst_ni (rst_n),
        .en_i   (poll_en),
        .tick_o (poll_tick)
    );

    always_comb begin
        state_d       = state_q;
        reg_idx_d     = reg_idx_q;
        regs_d        = regs_q;
        gap_cnt_d     = gap_cnt_q + 8'd1;
        wait_cnt_d    = wait_cnt_q + 8'd1;
        poll_pend_d   = poll_pend_q;
        wr_spi_data_d = wr_spi_data_q;
        cfg_busy_d    = cfg_busy_q;
        cfg_err_d     = cfg_err_q;
        pwr_data_d    = pwr_data_q;
        pwr_vld_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A configuration request takes priority; a pending poll waits for it.
                if (cfg_start) begin
                    regs_d     = cfg_data;
                    cfg_err_d  = 1'b0;
                    reg_idx_d  = 3'(NUM_REGS - 1);
                    cfg_busy_d = 1'b1;
                    state_d    = StWrReq;
                end else if (poll_pend_q) begin
                    state_d = StRdReq;
                end
            end
            StWrReq: begin
                wait_cnt_d = '0;
                state_d    = StWrWait;
            end
            StWrWait: begin
                if (update_vld) begin
                    if (reg_idx_q == 3'd0) begin
                        cfg_busy_d = 1'b0;
                        state_d    = StDone;
                    end else begin
                        reg_idx_d = reg_idx_q - 3'd1;
                        gap_cnt_d = '0;
                        state_d   = StGap;
                    end
                end else if (wait_cnt_q == TIMEOUT - 8'd1) begin
                    cfg_err_d  = 1'b1;
                    cfg_busy_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            StGap: begin
                if (gap_cnt_q + 8'd1 >= GAP_CYC) begin
                    state_d = StWrReq;
                end
            end
            StRdReq: begin
                poll_pend_d = 1'b0;
                wait_cnt_d  = '0;
                state_d     = StRdWait;
            end
            StRdWait: begin
                // dout_vld may stay high several cycles; only its rising edge is a new result.
                if (dout_vld && !dout_vld_q) begin
                    pwr_data_d = spi_dout;
                    pwr_vld_d  = 1'b1;
                    state_d    = StIdle;
                end else if (wait_cnt_q == TIMEOUT - 8'd1) begin
                    cfg_err_d  = 1'b1;
                    cfg_busy_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (poll_tick) begin
            poll_pend_d = 1'b1;
        end
        if (!poll_en) begin
            poll_pend_d = 1'b0;
        end

        // Load the outgoing word on entry to WR_REQ and hold it until the next write.
        if (state_d == StWrReq && state_q != StWrReq) begin
            wr_spi_data_d = reg_word(regs_d, reg_idx_d);
        end

        wr_en_d    = (state_d == StWrReq);
        rd_en_d    = (state_d == StRdReq);
        cfg_done_d = (state_d == StDone);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            reg_idx_q     <= '0;
            regs_q        <= '0;
            gap_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            poll_pend_q   <= 1'b0;
            dout_vld_q    <= 1'b0;
            wr_spi_data_q <= '0;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            cfg_busy_q    <= 1'b0;
            cfg_done_q    <= 1'b0;
            cfg_err_q     <= 1'b0;
            pwr_data_q    <= '0;
            pwr_vld_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            reg_idx_q     <= reg_idx_d;
            regs_q        <= regs_d;
            gap_cnt_q     <= gap_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            poll_pend_q   <= poll_pend_d;
            dout_vld_q    <= dout_vld;
            wr_spi_data_q <= wr_spi_data_d;
            wr_en_q       <= wr_en_d;
            rd_en_q       <= rd_en_d;
            cfg_busy_q    <= cfg_busy_d;
            cfg_done_q    <= cfg_done_d;
            cfg_err_q     <= cfg_err_d;
            pwr_data_q    <= pwr_data_d;
            pwr_vld_q     <= pwr_vld_d;
        end
    end

    assign wr_spi_data = wr_spi_data_q;
    assign wr_en       = wr_en_q;
    assign rd_en       = rd_en_q;
    assign cfg_busy    = cfg_busy_q;
    assign cfg_done    = cfg_done_q;
    assign cfg_err     = cfg_err_q;
    assign pwr_data    = pwr_data_q;
    assign pwr_vld     = pwr_vld_q;

endmodule

// File: tb/tb_adf4351_cfg_seq.sv
// Directed bench for adf4351_cfg_seq with behavioural SPI write/read responders and a
// negedge monitor that logs write words, gaps, reads and completion pulses.
module tb_adf4351_cfg_seq;

    localparam logic [31:0] R5 = 32'h0058_0005;
    localparam logic [31:0] R4 = 32'h008C_803C;
    localparam logic [31:0] R3 = 32'h0000_04B3;
    localparam logic [31:0] R2 = 32'h0000_4E42;
    localparam logic [31:0] R1 = 32'h0800_8011;
    localparam logic [31:0] R0 = 32'h0032_0000;

    logic         sys_clk;
    logic         rst_n;
    logic         cfg_start;
    logic [191:0] cfg_data;
    logic         poll_en;
    logic [31:0]  wr_spi_data;
    logic         wr_en;
    logic         rd_en;
    logic         update_vld;
    logic [15:0]  spi_dout;
    logic         dout_vld;
    logic         cfg_busy;
    logic         cfg_done;
    logic         cfg_err;
    logic [15:0]  pwr_data;
    logic         pwr_vld;

    adf4351_cfg_seq #(
        .POLL_DIV (20'd100),
        .GAP_CYC  (8'd4),
        .TIMEOUT  (8'd120)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .cfg_start   (cfg_start),
        .cfg_data    (cfg_data),
        .poll_en     (poll_en),
        .wr_spi_data (wr_spi_data),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .update_vld  (update_vld),
        .spi_dout    (spi_dout),
        .dout_vld    (dout_vld),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .pwr_data    (pwr_data),
        .pwr_vld     (pwr_vld)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Monitor state
    int          wr_cnt = 0, rd_cnt = 0, done_cnt = 0, pv_cnt = 0;
    int          last_ack_cyc = 0, err_cyc = 0, both_err = 0, stab_err = 0;
    logic        err_prev = 1'b0, pend = 1'b0;
    logic [31:0] pend_word = '0;
    logic [31:0] wr_words [64];
    int          wr_cyc [64];
    int          wr_gap [64];
    int          rd_cyc [64];

    always @(negedge sys_clk) begin
        if (wr_en) begin
            wr_words[wr_cnt % 64] <= wr_spi_data;
            wr_cyc[wr_cnt % 64]   <= cyc;
            wr_gap[wr_cnt % 64]   <= cyc - last_ack_cyc;
            wr_cnt                <= wr_cnt + 1;
            pend                  <= 1'b1;
            pend_word             <= wr_spi_data;
        end else if (pend && rst_n && wr_spi_data !== pend_word) begin
            stab_err <= stab_err + 1;
        end
        if (update_vld) begin
            last_ack_cyc <= cyc;
            pend         <= 1'b0;
        end
        if (!rst_n) pend <= 1'b0;
        if (rd_en) begin
            rd_cyc[rd_cnt % 64] <= cyc;
            rd_cnt              <= rd_cnt + 1;
        end
        if (cfg_done) done_cnt <= done_cnt + 1;
        if (pwr_vld) pv_cnt <= pv_cnt + 1;
        if (wr_en && rd_en) both_err <= both_err + 1;
        if (cfg_err && !err_prev) err_cyc <= cyc;
        err_prev <= cfg_err;
    end

    // SPI write responder: acks 82 cycles after a request unless told to go silent or a reset
    // (epoch change) intervened.
    int epoch = 0;
    int ack_total = 0;
    int ack_stop = 1000000;
    int wr_ep, rd_ep;

    initial begin : spi_wr_model
        update_vld = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (wr_en && ack_total < ack_stop) begin
                wr_ep = epoch;
                repeat (82) @(posedge sys_clk);
                #1;
                if (wr_ep == epoch) begin
                    update_vld = 1'b1;
                    ack_total  = ack_total + 1;
                    @(posedge sys_clk);
                    #1 update_vld = 1'b0;
                end
            end
        end
    end

    initial begin : spi_rd_model
        dout_vld = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (rd_en) begin
                rd_ep = epoch;
                repeat (4) @(posedge sys_clk);
                #1;
                if (rd_ep == epoch) begin
                    dout_vld = 1'b1;
                    repeat (3) @(posedge sys_clk);
                    #1 dout_vld = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge sys_clk);
        cfg_start = 1'b1;
        @(negedge sys_clk);
        cfg_start = 1'b0;
    endtask

    initial begin : stim
        logic [31:0] exp_words [6];
        int n, b_wr, b_rd, b_done, b_pv;

        exp_words = '{R5, R4, R3, R2, R1, R0};
        rst_n     = 1'b0;
        cfg_start = 1'b0;
        poll_en   = 1'b0;
        spi_dout  = 16'h0000;
        cfg_data  = {R5, R4, R3, R2, R1, R0};

        // Reset state
        repeat (3) @(negedge sys_clk);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_rd_en", {31'd0, rd_en}, 32'd0);
        check("rst_busy", {31'd0, cfg_busy}, 32'd0);
        check("rst_done", {31'd0, cfg_done}, 32'd0);
        check("rst_err", {31'd0, cfg_err}, 32'd0);
        check("rst_pwr_vld", {31'd0, pwr_vld}, 32'd0);
        check("rst_wr_data", wr_spi_data, 32'd0);
        check("rst_pwr_data", {16'd0, pwr_data}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        // Full configuration, with a second cfg_start while busy that must be ignored
        b_wr = wr_cnt; b_done = done_cnt;
        pulse_start();
        check("s1_busy_after_start", {31'd0, cfg_busy}, 32'd1);
        repeat (50) @(negedge sys_clk);
        pulse_start();
        n = 0;
        while (!cfg_done && n < 2000) begin @(negedge sys_clk); n++; end
        check("s1_done_seen", {31'd0, cfg_done}, 32'd1);
        check("s1_busy_at_done", {31'd0, cfg_busy}, 32'd0);
        repeat (3) @(negedge sys_clk);
        check("s1_wr_count", wr_cnt - b_wr, 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("s1_word%0d", i),
                                          wr_words[(b_wr + i) % 64], exp_words[i]);
        // update_vld cycle, four idle gap cycles, then the next wr_en
        for (int i = 1; i < 6; i++) check($sformatf("s1_gap%0d", i), wr_gap[(b_wr + i) % 64], 32'd5);
        check("s1_done_count", done_cnt - b_done, 32'd1);
        check("s1_err", {31'd0, cfg_err}, 32'd0);

        // Responder goes silent after R4: R3 write must time out
        ack_stop = ack_total + 2;
        b_wr = wr_cnt; b_done = done_cnt;
        pulse_start();
        n = 0;
        while (!cfg_err && n < 2000) begin @(negedge sys_clk); n++; end
        repeat (2) @(negedge sys_clk);
        ack_stop = 1000000;
        check("s2_err", {31'd0, cfg_err}, 32'd1);
        check("s2_busy", {31'd0, cfg_busy}, 32'd0);
        check("s2_wr_count", wr_cnt - b_wr, 32'd3);
        check("s2_no_done", done_cnt - b_done, 32'd0);
        // wr_en cycle + 120 cycles in WR_WAIT
        check("s2_timeout_cycles", err_cyc - wr_cyc[(b_wr + 2) % 64], 32'd121);

        // Periodic power-detect reads
        spi_dout = 16'h0ABC;
        b_rd = rd_cnt; b_pv = pv_cnt;
        @(negedge sys_clk);
        poll_en = 1'b1;
        n = 0;
        while (pv_cnt - b_pv < 3 && n < 500) begin @(negedge sys_clk); n++; end
        poll_en = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("s3_rd_count", rd_cnt - b_rd, 32'd3);
        check("s3_pv_count", pv_cnt - b_pv, 32'd3);
        check("s3_pwr_data", {16'd0, pwr_data}, 32'h0ABC);
        check("s3_period1", rd_cyc[(b_rd + 1) % 64] - rd_cyc[b_rd % 64], 32'd100);
        check("s3_period2", rd_cyc[(b_rd + 2) % 64] - rd_cyc[(b_rd + 1) % 64], 32'd100);
        repeat (250) @(negedge sys_clk);
        check("s3_disabled_no_rd", rd_cnt - b_rd, 32'd3);

        // Poll wrap and cfg_start in the same cycle: writes first, then one read
        spi_dout = 16'h1234;
        b_wr = wr_cnt; b_rd = rd_cnt; b_pv = pv_cnt; b_done = done_cnt;
        @(negedge sys_clk);
        poll_en = 1'b1;
        repeat (99) @(posedge sys_clk);
        @(negedge sys_clk);
        cfg_start = 1'b1;
        @(negedge sys_clk);
        cfg_start = 1'b0;
        check("s4_busy_after_start", {31'd0, cfg_busy}, 32'd1);
        check("s4_err_cleared", {31'd0, cfg_err}, 32'd0);
        n = 0;
        while (!cfg_done && n < 2000) begin @(negedge sys_clk); n++; end
        check("s4_done_seen", {31'd0, cfg_done}, 32'd1);
        check("s4_no_rd_before_done", rd_cnt - b_rd, 32'd0);
        n = 0;
        while (pv_cnt - b_pv < 1 && n < 100) begin @(negedge sys_clk); n++; end
        poll_en = 1'b0;
        repeat (30) @(negedge sys_clk);
        check("s4_wr_count", wr_cnt - b_wr, 32'd6);
        check("s4_rd_count", rd_cnt - b_rd, 32'd1);
        check("s4_pv_count", pv_cnt - b_pv, 32'd1);
        check("s4_pwr_data", {16'd0, pwr_data}, 32'h1234);

        // Reset while R2 is being written
        b_done = done_cnt;
        pulse_start();
        n = 0;
        while (!(wr_en && wr_spi_data == R2) && n < 1000) begin @(negedge sys_clk); n++; end
        check("s5_r2_seen", {31'd0, wr_en}, 32'd1);
        #1;
        rst_n = 1'b0;
        epoch = epoch + 1;
        #1;
        check("s5_rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("s5_rst_wr_data", wr_spi_data, 32'd0);
        check("s5_rst_busy", {31'd0, cfg_busy}, 32'd0);
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (100) @(negedge sys_clk);
        check("s5_no_done", done_cnt - b_done, 32'd0);
        check("s5_no_wr_after_rst", {31'd0, wr_en}, 32'd0);
        b_wr = wr_cnt;
        pulse_start();
        n = 0;
        while (!wr_en && n < 20) begin @(negedge sys_clk); n++; end
        check("s5_restart_r5", wr_spi_data, R5);
        n = 0;
        while (!cfg_done && n < 2000) begin @(negedge sys_clk); n++; end
        repeat (3) @(negedge sys_clk);
        check("s5_wr_count", wr_cnt - b_wr, 32'd6);
        check("s5_done_count", done_cnt - b_done, 32'd1);
        check("s5_err", {31'd0, cfg_err}, 32'd0);

        check("never_wr_and_rd", both_err, 32'd0);
        check("wr_data_stable", stab_err, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adf4351_cfg_seq.md
ADF4351_CFG_SEQ -- requirements
Module: adf4351_cfg_seq

Interface
REQ-001 Parameter POLL_DIV, default 20'd400000: sys_clk cycles between power-detect read requests.
REQ-002 Parameter GAP_CYC, default 8'd4: idle cycles between consecutive SPI transactions.
REQ-003 Parameter TIMEOUT, default 8'd120: maximum cycles to wait for update_vld or dout_vld.
REQ-004 sys_clk  in  1  the only clock.
REQ-005 rst_n  in  1  asynchronous reset, active-low.
REQ-006 cfg_start  in  1  one-cycle pulse that starts programming all six ADF4351 registers.
REQ-007 cfg_data  in  192  R5 at [191:160] down to R0 at [31:0], each with control bits already set.
REQ-008 poll_en  in  1  level; enables periodic power-detect reads.
REQ-009 wr_spi_data  out  32  word presented to the SPI writer.
REQ-010 wr_en  out  1  one-cycle write request to the SPI writer.
REQ-011 rd_en  out  1  one-cycle read request to the SPI reader.
REQ-012 update_vld  in  1  one-cycle write-complete pulse from the SPI controller.
REQ-013 spi_dout  in  16  read result from the SPI controller.
REQ-014 dout_vld  in  1  read-valid from the SPI controller, high for up to 3 cycles.
REQ-015 cfg_busy  out  1  high from the cycle after an accepted cfg_start until DONE or an abort.
REQ-016 cfg_done  out  1  one-cycle pulse after R0 completes.
REQ-017 cfg_err  out  1  sticky timeout flag; cleared by the next accepted cfg_start.
REQ-018 pwr_data  out  16  last captured power reading.
REQ-019 pwr_vld  out  1  one-cycle pulse when pwr_data updates.

Function
REQ-020 The FSM SHALL have states IDLE, WR_REQ, WR_WAIT, GAP, RD_REQ, RD_WAIT, DONE.
REQ-021 IDLE SHALL go to WR_REQ on cfg_start, else to RD_REQ on poll_pend; when both occur in the same cycle, cfg_start wins and poll_pend stays set.
REQ-022 On accept, the block SHALL latch cfg_data, clear cfg_err and set reg_idx=5.
REQ-023 WR_REQ SHALL drive wr_spi_data=reg[reg_idx] and wr_en=1 for exactly one cycle, then go to WR_WAIT.
REQ-024 wr_spi_data SHALL stay stable from WR_REQ until update_vld.
REQ-025 WR_WAIT on update_vld: if reg_idx=0, go to DONE; otherwise decrement reg_idx and go to GAP.
REQ-026 GAP SHALL count GAP_CYC cycles and then return to WR_REQ.
REQ-027 Writes SHALL go out in order R5,R4,R3,R2,R1,R0: six wr_en pulses per configuration.
REQ-028 DONE SHALL pulse cfg_done for one cycle, drop cfg_busy and return to IDLE.
REQ-029 RD_REQ SHALL pulse rd_en for one cycle, clear poll_pend and go to RD_WAIT.
REQ-030 RD_WAIT SHALL capture spi_dout into pwr_data on the rising edge of dout_vld only, pulse pwr_vld in the next cycle and return to IDLE.
REQ-031 The wait timer SHALL reset on entry to WR_WAIT or RD_WAIT.
REQ-032 When the wait timer reaches TIMEOUT: set cfg_err, drop cfg_busy, go to IDLE and emit no cfg_done or pwr_vld.
REQ-033 The poll counter SHALL run only while poll_en=1, wrap at POLL_DIV-1 and set poll_pend on wrap.
REQ-034 poll_en=0 SHALL clear the poll counter and poll_pend.
REQ-035 cfg_start while not IDLE SHALL be ignored.
REQ-036 A poll request arriving during configuration SHALL be held in poll_pend and serviced after DONE.
REQ-037 wr_en and rd_en SHALL never be high in the same cycle.
REQ-038 No new request SHALL be issued while a transaction is outstanding.

Reset
REQ-039 rst_n low SHALL immediately force: state IDLE; wr_en, rd_en, cfg_busy, cfg_done, cfg_err, pwr_vld = 0; wr_spi_data, pwr_data = 0; reg_idx, counters, poll_pend = 0.
REQ-040 Reset mid-transaction SHALL abort without any completion pulse.
REQ-041 After reset release, the first request SHALL require a fresh cfg_start or poll wrap.

Structure
REQ-042 A shared package SHALL hold the state encoding, NUM_REGS=6 and the default values of POLL_DIV, GAP_CYC and TIMEOUT.
REQ-043 The block SHALL contain one sub-module, cfg_poll_timer: the POLL_DIV tick generator with enable.
REQ-044 The block SHALL instantiate no SPI logic; it connects to the existing SPI controller ports only.

Verification
REQ-045 Scenario: cfg_start with R5..R0 = 0x00580005, 0x008C803C, 0x000004B3, 0x00004E42, 0x08008011, 0x00320000, with an SPI model acking after 82 cycles -> six wr_en pulses carrying those words in that order, gaps of 4 cycles, one cfg_done, cfg_err=0.
REQ-046 Scenario: the model never returns update_vld after R3 -> cfg_err=1 exactly 120 cycles after WR_WAIT entry, only three wr_en pulses, no cfg_done.
REQ-047 Scenario: POLL_DIV=100, poll_en=1, spi_dout=0x0ABC with a 3-cycle dout_vld -> rd_en every 100 cycles, pwr_data=0x0ABC, exactly one pwr_vld per read.
REQ-048 Scenario: poll wrap and cfg_start in the same cycle -> all six writes complete first, then exactly one rd_en.
REQ-049 Scenario: rst_n low during the write of R2 -> all outputs 0 within the same cycle, no cfg_done; a following cfg_start restarts from R5.
REQ-050 Scenario: cfg_start pulsed while cfg_busy=1 -> ignored; the total wr_en count stays 6.
